// File: rtl/bcd_subtractor_seq_pkg.sv
// rtl/bcd_subtractor_seq_pkg.sv - shared constants, state encoding and index-width helper
package bcd_subtractor_seq_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_SIX  = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // clog2 with a floor of one bit so a single-digit build still has an index register
  function automatic int idx_width(input int digits);
    int w;
    w = 1;
    while ((1 << w) < digits) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - combinational single-digit BCD adder with +6 correction
module bcd_digit_add
  import bcd_subtractor_seq_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] bin_sum;

  always_comb begin
    bin_sum = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    cout    = (bin_sum > 5'd9);
    s       = cout ? (bin_sum[3:0] + BCD_SIX) : bin_sum[3:0];
  end

endmodule

// File: rtl/bcd_subtractor_seq.sv
// rtl/bcd_subtractor_seq.sv - digit-serial packed-BCD subtractor returning |a-b| and a sign flag
module bcd_subtractor_seq
  import bcd_subtractor_seq_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] diff,
  output logic                    neg,
  output logic                    invalid
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int IW = idx_width(DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, diff_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q, neg_q, invalid_q, done_q, busy_q;

  logic [3:0]      a_dig, b_dig, r_dig;
  logic [3:0]      x_d, y_d, sum_d;
  logic            cout_d;
  logic            in_bad;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[i*DIGIT_W +: DIGIT_W] > BCD_NINE || b[i*DIGIT_W +: DIGIT_W] > BCD_NINE)
        in_bad = 1'b1;
    end
  end

  // One adder serves both passes: SUB adds a_i + (9-b_i), NEG adds 0 + (9-r_i)
  always_comb begin
    a_dig = a_q[idx_q*DIGIT_W +: DIGIT_W];
    b_dig = b_q[idx_q*DIGIT_W +: DIGIT_W];
    r_dig = diff_q[idx_q*DIGIT_W +: DIGIT_W];
    x_d   = (state_q == S_SUB) ? a_dig : 4'd0;
    y_d   = BCD_NINE - ((state_q == S_SUB) ? b_dig : r_dig);
  end

  bcd_digit_add u_digit_add (
    .x    (x_d),
    .y    (y_d),
    .cin  (carry_q),
    .s    (sum_d),
    .cout (cout_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      diff_q    <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      neg_q     <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            busy_q  <= 1'b1;
            neg_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b1;
            if (in_bad) begin
              invalid_q <= 1'b1;
              diff_q    <= '0;
              state_q   <= S_DONE;
            end else begin
              invalid_q <= 1'b0;
              state_q   <= S_SUB;
            end
          end
        end
        S_SUB: begin
          diff_q[idx_q*DIGIT_W +: DIGIT_W] <= sum_d;
          carry_q <= cout_d;
          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            if (cout_d) begin
              state_q <= S_DONE;
            end else begin
              // No final carry: intermediate is the ten's complement of the magnitude
              neg_q   <= 1'b1;
              carry_q <= 1'b1;
              state_q <= S_NEG;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_NEG: begin
          diff_q[idx_q*DIGIT_W +: DIGIT_W] <= sum_d;
          carry_q <= cout_d;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign diff    = diff_q;
  assign neg     = neg_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// tb/tb_bcd_subtractor_seq.sv - self-checking bench for bcd_subtractor_seq
module tb_bcd_subtractor_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_r, b_r;
  logic         busy, done, neg, invalid;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_subtractor_seq #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_r),
    .b       (b_r),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .neg     (neg),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decode to integers, subtract, re-encode
  function automatic void model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                output logic [W-1:0] ed, output logic en,
                                output logic ei, output int el);
    int av, bv, m;
    bit bad;
    logic [3:0] da, db;
    av = 0; bv = 0; bad = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      da = ai[i*4 +: 4];
      db = bi[i*4 +: 4];
      if (da > 9 || db > 9) bad = 1;
      av = av * 10 + int'(da);
      bv = bv * 10 + int'(db);
    end
    ed = '0;
    if (bad) begin
      en = 0; ei = 1; el = 1;
      return;
    end
    ei = 0;
    en = (av < bv);
    m  = en ? (bv - av) : (av - bv);
    for (int i = 0; i < DIGITS; i++) begin
      ed[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    el = en ? (2 * DIGITS + 1) : (DIGITS + 1);
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Drives one operation and reports what was seen; comparisons live in the callers
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input bit hold,
                       output int lat, output logic [W-1:0] d, output logic n,
                       output logic inv, output logic bz,
                       output logic done_after, output logic busy_after);
    a_r = ai; b_r = bi; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (hold) begin a_r = W'($urandom); b_r = W'($urandom); end
      if (done) begin lat = k; break; end
    end
    d = diff; n = neg; inv = invalid; bz = busy;
    @(negedge clk);
    done_after = done; busy_after = busy;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_r = '0; b_r = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, diff, neg, invalid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h neg=%b inv=%b, want all 0",
               busy, done, diff, neg, invalid);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{16'h0042, 16'h0017, 16'h1000, 16'h0000, 16'h0573, 16'h9999};
    logic [W-1:0] tb [6] = '{16'h0017, 16'h0042, 16'h0001, 16'h9999, 16'h0573, 16'h0000};
    logic [W-1:0] td [6] = '{16'h0025, 16'h0025, 16'h0999, 16'h9999, 16'h0000, 16'h9999};
    logic         tn [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int           tl [6] = '{5, 9, 5, 9, 5, 5};
    int lat; logic [W-1:0] d; logic n, inv, bz, da, ba;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], 0, lat, d, n, inv, bz, da, ba);
      n_checks++;
      if (lat !== tl[i]) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: got %0d, want %0d", i, lat, tl[i]);
      end
      n_checks++;
      if ({d, n, inv} !== {td[i], tn[i], 1'b0}) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: got diff=%h neg=%b inv=%b, want diff=%h neg=%b inv=0",
                 i, d, n, inv, td[i], tn[i]);
      end
      n_checks++;
      if ({bz, da, ba} !== 3'b100) begin
        n_fail++;
        $display("FAIL dir_handshake[%0d]: got busy@done=%b done+1=%b busy+1=%b, want 1 0 0",
                 i, bz, da, ba);
      end
    end
  endtask

  task automatic test_invalid();
    int lat; logic [W-1:0] d; logic n, inv, bz, da, ba;
    do_op(16'h00A1, 16'h0003, 0, lat, d, n, inv, bz, da, ba);
    n_checks++;
    if ({lat == 1, d, n, inv} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL invalid_op: got lat=%0d diff=%h neg=%b inv=%b, want lat=1 diff=0000 neg=0 inv=1",
               lat, d, n, inv);
    end
    do_op(16'h0050, 16'h0000, 0, lat, d, n, inv, bz, da, ba);
    n_checks++;
    if ({lat == 5, d, n, inv} !== {1'b1, 16'h0050, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL invalid_cleared: got lat=%0d diff=%h neg=%b inv=%b, want lat=5 diff=0050 neg=0 inv=0",
               lat, d, n, inv);
    end
  endtask

  task automatic test_random();
    int lat, el; logic [W-1:0] d, ai, bi, ed; logic n, inv, bz, da, ba, en, ei;
    for (int i = 0; i < 40; i++) begin
      ai = rand_bcd();
      bi = (i % 7 == 3) ? ai : rand_bcd();
      if (i % 10 == 5) bi[($urandom_range(0, DIGITS - 1))*4 +: 4] = 4'($urandom_range(10, 15));
      model(ai, bi, ed, en, ei, el);
      do_op(ai, bi, 0, lat, d, n, inv, bz, da, ba);
      n_checks++;
      if ({d, n, inv} !== {ed, en, ei}) begin
        n_fail++;
        $display("FAIL rand_result[%0d] a=%h b=%h: got diff=%h neg=%b inv=%b, want diff=%h neg=%b inv=%b",
                 i, ai, bi, d, n, inv, ed, en, ei);
      end
      n_checks++;
      if (lat !== el) begin
        n_fail++;
        $display("FAIL rand_latency[%0d] a=%h b=%h: got %0d, want %0d", i, ai, bi, lat, el);
      end
    end
  endtask

  task automatic test_handshake();
    int lat, pulses; logic [W-1:0] d; logic n, inv, bz, da, ba;
    do_op(16'h0017, 16'h0042, 1, lat, d, n, inv, bz, da, ba);
    n_checks++;
    if ({lat == 9, d, n, inv, da} !== {1'b1, 16'h0025, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL held_start: got lat=%0d diff=%h neg=%b inv=%b done+1=%b, want lat=9 diff=0025 neg=1 inv=0 done+1=0",
               lat, d, n, inv, da);
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL no_extra_op: got %0d busy/done cycles after start dropped, want 0", pulses);
    end
  endtask

  task automatic test_reset_midop();
    int lat, pulses; logic [W-1:0] d; logic n, inv, bz, da, ba;
    a_r = 16'h0017; b_r = 16'h0042; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, diff, neg, invalid} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: got busy=%b done=%b diff=%h neg=%b inv=%b, want all 0",
               busy, done, diff, neg, invalid);
    end
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL midop_no_done: got %0d done cycles, want 0", pulses);
    end
    do_op(16'h0300, 16'h0123, 0, lat, d, n, inv, bz, da, ba);
    n_checks++;
    if ({lat == 5, d, n, inv} !== {1'b1, 16'h0177, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_op: got lat=%0d diff=%h neg=%b inv=%b, want lat=5 diff=0177 neg=0 inv=0",
               lat, d, n, inv);
    end
  endtask

  task automatic test_back_to_back();
    int lat, el; logic [W-1:0] d, ai, bi, ed; logic n, inv, bz, da, ba, en, ei;
    for (int i = 0; i < 4; i++) begin
      ai = rand_bcd(); bi = rand_bcd();
      model(ai, bi, ed, en, ei, el);
      do_op(ai, bi, 0, lat, d, n, inv, bz, da, ba);
      n_checks++;
      if ({lat, d, n, inv} !== {el, ed, en, ei}) begin
        n_fail++;
        $display("FAIL b2b[%0d] a=%h b=%h: got lat=%0d diff=%h neg=%b inv=%b, want lat=%0d diff=%h neg=%b inv=%b",
                 i, ai, bi, lat, d, n, inv, el, ed, en, ei);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_invalid();
    test_random();
    test_handshake();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_subtractor_seq.md
Name: bcd_subtractor_seq

Overview:
- Digit-serial, multi-digit packed-BCD subtractor; computes |A − B| plus a sign flag.
- Complements the team's combinational BCD adder datapath by providing subtraction.
- Method: ten's complement, processing one BCD digit per clock, least-significant digit (LSD) first.
- Start/busy/done handshake; sits between operand registers and the display/result register in the BCD arithmetic unit.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  4*DIGITS  minuend, packed BCD; digit i = a[4i+3:4i].
- b  input  4*DIGITS  subtrahend, packed BCD.
- busy  output  1  high while an operation is in progress (SUB, NEG or DONE state).
- done  output  1  one-cycle pulse; result valid from this cycle on.
- diff  output  4*DIGITS  magnitude |a − b|, packed BCD.
- neg  output  1  1 when a < b.
- invalid  output  1  1 when any input digit is > 9.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, neg=0, invalid=0; digit index and carry cleared. Reset mid-operation aborts the operation with no done pulse.
- IDLE, start=1 at edge E0:
  - Latch a and b internally.
  - If any digit of a or b is > 9: invalid=1, diff=0, neg=0, go to DONE.
  - Otherwise: invalid=0, carry=1, index=0, go to SUB.
- SUB (DIGITS cycles, index 0..DIGITS-1):
  - r_i = BCD-corrected a_i + (9 − b_i) + carry.
  - Correction adds 6 when the binary sum is > 9; digit carry-out becomes the next carry.
  - r_i is written into the diff register at digit i.
  - After the last digit:
    - Final carry=1: neg=0, go to DONE.
    - Final carry=0: neg=1, carry=1, index=0, go to NEG.
- NEG (DIGITS cycles): diff_i = BCD-corrected (9 − diff_i) + carry, LSD first. This is ten's complement of the intermediate result, giving the magnitude.
- DONE (one cycle): done=1, busy=1, then go to IDLE with busy=0.
- Latency, with E0 as the accepting edge and cycle k being the cycle after edge Ek:
  - Positive or zero result: done in cycle DIGITS+1.
  - Negative result: done in cycle 2*DIGITS+1.
  - Invalid input: done in cycle 1.
- diff, neg and invalid hold their values until the next accepted start. They are updated only while busy, and their contents are unspecified while busy=1.
- Any start while busy=1 is ignored, and a/b changes while busy have no effect because the operands are latched.
- Zero result is always reported neg=0 (a = b produces final carry 1).
- Nine's complement logic must handle only digits 0..9 (invalid digits never reach SUB).
- No overflow is possible: |a − b| ≤ 10^DIGITS − 1.

Decomposition:
- Shared package:
  - DIGIT_W=4.
  - BCD_NINE=4'd9.
  - BCD_SIX=4'd6.
  - State encoding IDLE/SUB/NEG/DONE (2-bit).
  - Digit-index width function clog2(DIGITS).
- Sub-module: bcd_digit_add. Combinational single-digit adder: inputs x[3:0], y[3:0], cin; outputs s[3:0], cout; applies the +6 correction. It is instantiated once and shared by SUB and NEG via an operand mux (x = a_i or 0; y = 9 − b_i or 9 − diff_i).
- Top module holds the FSM, operand latches, shift/index logic and output registers.

Test Plan:
- a=0x0042, b=0x0017, start pulsed → done in cycle 5, diff=0x0025, neg=0, invalid=0.
- a=0x0017, b=0x0042 → done in cycle 9, diff=0x0025, neg=1.
- a=0x1000, b=0x0001 → diff=0x0999, neg=0 (full borrow chain). Also a=0x0000, b=0x9999 → diff=0x9999, neg=1.
- a=0x0573, b=0x0573 → diff=0x0000, neg=0, done in cycle 5. Also a=0x9999, b=0x0000 → diff=0x9999, neg=0.
- a=0x00A1, b=0x0003 → invalid=1, diff=0, neg=0, done in cycle 1; a following valid op clears invalid.
- Handshake/reset checks:
  - start held high plus operand changes during busy → single done and result from the original operands.
  - rst_n pulled low in cycle 3 of an operation → all outputs 0 immediately, no done pulse, next start works normally.
